regfile_scoreboard: RTL and testbench

//  CPU general-purpose register file with an integrated pending-write scoreboard.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/onehot_decoder.sv | 19 +
 rtl/regfile_scoreboard.sv | 119 +++++++++++
 tb/tb_regfile_scoreboard.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file types and defaults for the CPU datapath.
package cpu_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 16;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = 3'd0;

endpackage

// File: rtl/onehot_decoder.sv
// Gated binary-to-one-hot decoder; addresses at or beyond OUT_N select nothing.
module onehot_decoder #(
  parameter int IN_W  = 3,
  parameter int OUT_N = 8
) (
  input  logic             en,
  input  logic [IN_W-1:0]  addr,
  output logic [OUT_N-1:0] sel
);

  // One select line per output, qualified by the enable
  always_comb begin
    sel = {OUT_N{1'b0}};
    for (int i = 0; i < OUT_N; i++) begin
      sel[i] = en & (addr == IN_W'(i));
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with write-to-read bypass and a per-register
// pending-write scoreboard used by issue to decide stalls.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   ra1,
  output logic [DATA_W-1:0]   rd1,
  output logic                busy1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rd2,
  output logic                busy2,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic                iv,
  input  logic [ADDR_W-1:0]   ia,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [NUM_REGS-1:0] VALID_MASK =
    ZERO_REG ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] wdec_s;
  logic [NUM_REGS-1:0] idec_s;
  logic [NUM_REGS-1:0] wsel_s;
  logic [NUM_REGS-1:0] isel_s;
  logic [NUM_REGS-1:0] wbyp_s;
  logic [NUM_REGS-1:0] hit1_s;
  logic [NUM_REGS-1:0] hit2_s;
  logic [DATA_W-1:0]   rd1_s;
  logic [DATA_W-1:0]   rd2_s;
  logic                busy1_s;
  logic                busy2_s;

  onehot_decoder #(.IN_W(ADDR_W), .OUT_N(NUM_REGS)) u_wdec (
    .en   (we),
    .addr (wa),
    .sel  (wdec_s)
  );

  onehot_decoder #(.IN_W(ADDR_W), .OUT_N(NUM_REGS)) u_idec (
    .en   (iv),
    .addr (ia),
    .sel  (idec_s)
  );

  // Read-address match restricted to valid registers; invalid addresses hit nothing
  function automatic logic [NUM_REGS-1:0] addr_hit(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] hit;
    hit = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (a == ADDR_W'(i));
    end
    if (ZERO_REG && (a == ADDR_W'(ZERO_ADDR))) begin
      hit = {NUM_REGS{1'b0}};
    end else begin
      hit = hit & VALID_MASK;
    end
    return hit;
  endfunction

  // Valid-qualified selects plus the read muxes with bypass and busy masking
  always_comb begin
    wsel_s  = wdec_s & VALID_MASK;
    isel_s  = idec_s & VALID_MASK;
    // While reset is held the bypass must not leak wd onto the read ports
    wbyp_s  = wsel_s & {NUM_REGS{rst_n}};
    hit1_s  = addr_hit(ra1);
    hit2_s  = addr_hit(ra2);
    rd1_s   = {DATA_W{1'b0}};
    rd2_s   = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd1_s = rd1_s | ({DATA_W{hit1_s[i]}} & (wbyp_s[i] ? wd : regs_r[i]));
      rd2_s = rd2_s | ({DATA_W{hit2_s[i]}} & (wbyp_s[i] ? wd : regs_r[i]));
    end
    busy1_s = |(hit1_s & busy_r & ~wbyp_s);
    busy2_s = |(hit2_s & busy_r & ~wbyp_s);
  end

  // Register storage: one write port driven by the gated write select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wsel_s[i]) begin
          regs_r[i] <= wd;
        end
      end
    end
  end

  // Scoreboard: a same-cycle issue beats the writeback since the new producer is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= (busy_r & ~wsel_s) | isel_s;
    end
  end

  assign rd1      = rd1_s;
  assign rd2      = rd2_s;
  assign busy1    = busy1_s;
  assign busy2    = busy2_s;
  assign busy_vec = busy_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default, zero-register and 6-register variants
// share one stimulus bus; each scenario checks the instance it targets.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ra1, ra2, wa, ia;
  logic        we, iv;
  logic [15:0] wd;

  logic [15:0] rd1_a, rd2_a, rd1_z, rd2_z, rd1_6, rd2_6;
  logic        busy1_a, busy2_a, busy1_z, busy2_z, busy1_6, busy2_6;
  logic [7:0]  busy_vec_a, busy_vec_z;
  logic [5:0]  busy_vec_6;

  int tests_run;
  int tests_failed;

  regfile_scoreboard u_a (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .rd1(rd1_a), .busy1(busy1_a),
    .ra2(ra2), .rd2(rd2_a), .busy2(busy2_a), .we(we), .wa(wa), .wd(wd),
    .iv(iv), .ia(ia), .busy_vec(busy_vec_a)
  );

  regfile_scoreboard #(.ZERO_REG(1'b1)) u_z (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .rd1(rd1_z), .busy1(busy1_z),
    .ra2(ra2), .rd2(rd2_z), .busy2(busy2_z), .we(we), .wa(wa), .wd(wd),
    .iv(iv), .ia(ia), .busy_vec(busy_vec_z)
  );

  regfile_scoreboard #(.NUM_REGS(6)) u_6 (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .rd1(rd1_6), .busy1(busy1_6),
    .ra2(ra2), .rd2(rd2_6), .busy2(busy2_6), .we(we), .wa(wa), .wd(wd),
    .iv(iv), .ia(ia), .busy_vec(busy_vec_6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    we = 1'b0;
    iv = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    tick();
    we = 1'b1; wa = 3'd3; wd = 16'h1234; iv = 1'b1; ia = 3'd3;
    tick();
    we = 1'b0; iv = 1'b0; ra1 = 3'd3; ra2 = 3'd3;
    #1;
    tests_run++; if (rd1_a !== 16'h1234) begin tests_failed++; $display("FAIL reset_pre_rd1: got %h expected %h", rd1_a, 16'h1234); end
    tests_run++; if (busy_vec_a !== 8'h08) begin tests_failed++; $display("FAIL reset_pre_busy: got %h expected %h", busy_vec_a, 8'h08); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (rd1_a !== 16'h0000) begin tests_failed++; $display("FAIL reset_rd1: got %h expected %h", rd1_a, 16'h0000); end
    tests_run++; if (busy_vec_a !== 8'h00) begin tests_failed++; $display("FAIL reset_busy_vec: got %h expected %h", busy_vec_a, 8'h00); end
    tests_run++; if (busy2_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy2: got %b expected %b", busy2_a, 1'b0); end
    #1;
    rst_n = 1'b1;
    tick();
    tests_run++; if (rd2_a !== 16'h0000) begin tests_failed++; $display("FAIL reset_post_rd2: got %h expected %h", rd2_a, 16'h0000); end
  endtask

  task automatic test_bypass;
    we = 1'b1; wa = 3'd5; wd = 16'hBEEF; ra1 = 3'd5; ra2 = 3'd6;
    #1;
    tests_run++; if (rd1_a !== 16'hBEEF) begin tests_failed++; $display("FAIL bypass_rd1: got %h expected %h", rd1_a, 16'hBEEF); end
    tests_run++; if (rd2_a !== 16'h0000) begin tests_failed++; $display("FAIL bypass_other_rd2: got %h expected %h", rd2_a, 16'h0000); end
    tick();
    we = 1'b0;
    #1;
    tests_run++; if (rd1_a !== 16'hBEEF) begin tests_failed++; $display("FAIL bypass_stored_rd1: got %h expected %h", rd1_a, 16'hBEEF); end
  endtask

  task automatic test_scoreboard;
    iv = 1'b1; ia = 3'd2; ra2 = 3'd2;
    #1;
    tests_run++; if (busy2_a !== 1'b0) begin tests_failed++; $display("FAIL sb_issue_same_cycle: got %b expected %b", busy2_a, 1'b0); end
    tick();
    iv = 1'b0;
    #1;
    tests_run++; if (busy_vec_a[2] !== 1'b1) begin tests_failed++; $display("FAIL sb_busy_vec2_set: got %b expected %b", busy_vec_a[2], 1'b1); end
    tests_run++; if (busy2_a !== 1'b1) begin tests_failed++; $display("FAIL sb_busy2_set: got %b expected %b", busy2_a, 1'b1); end
    we = 1'b1; wa = 3'd2; wd = 16'h0042;
    #1;
    tests_run++; if (busy2_a !== 1'b0) begin tests_failed++; $display("FAIL sb_busy2_wb_same_cycle: got %b expected %b", busy2_a, 1'b0); end
    tests_run++; if (rd2_a !== 16'h0042) begin tests_failed++; $display("FAIL sb_wb_bypass: got %h expected %h", rd2_a, 16'h0042); end
    tests_run++; if (busy_vec_a[2] !== 1'b1) begin tests_failed++; $display("FAIL sb_busy_vec2_before_edge: got %b expected %b", busy_vec_a[2], 1'b1); end
    tick();
    we = 1'b0;
    #1;
    tests_run++; if (busy_vec_a !== 8'h00) begin tests_failed++; $display("FAIL sb_busy_vec_cleared: got %h expected %h", busy_vec_a, 8'h00); end
    tests_run++; if (rd2_a !== 16'h0042) begin tests_failed++; $display("FAIL sb_rd2_stored: got %h expected %h", rd2_a, 16'h0042); end
  endtask

  task automatic test_set_vs_clear;
    tick();
    iv = 1'b1; ia = 3'd4;
    tick();
    iv = 1'b0;
    #1;
    tests_run++; if (busy_vec_a !== 8'h10) begin tests_failed++; $display("FAIL svc_r4_busy: got %h expected %h", busy_vec_a, 8'h10); end
    iv = 1'b1; ia = 3'd4; we = 1'b1; wa = 3'd4; wd = 16'h5A5A;
    tick();
    iv = 1'b0; we = 1'b0; ra1 = 3'd4;
    #1;
    tests_run++; if (busy_vec_a !== 8'h10) begin tests_failed++; $display("FAIL svc_set_wins: got %h expected %h", busy_vec_a, 8'h10); end
    tests_run++; if (rd1_a !== 16'h5A5A) begin tests_failed++; $display("FAIL svc_data_written: got %h expected %h", rd1_a, 16'h5A5A); end
    tests_run++; if (busy1_a !== 1'b1) begin tests_failed++; $display("FAIL svc_busy1: got %b expected %b", busy1_a, 1'b1); end
    we = 1'b1; wa = 3'd6; wd = 16'h0606; ra2 = 3'd6;
    tick();
    we = 1'b0;
    #1;
    tests_run++; if (rd2_a !== 16'h0606) begin tests_failed++; $display("FAIL wb_nonbusy_data: got %h expected %h", rd2_a, 16'h0606); end
    tests_run++; if (busy_vec_a !== 8'h10) begin tests_failed++; $display("FAIL wb_nonbusy_busy: got %h expected %h", busy_vec_a, 8'h10); end
    we = 1'b1; wa = 3'd4; wd = 16'h4444;
    tick();
    we = 1'b0;
    #1;
    tests_run++; if (busy_vec_a !== 8'h00) begin tests_failed++; $display("FAIL svc_final_clear: got %h expected %h", busy_vec_a, 8'h00); end
    tests_run++; if (rd1_a !== 16'h4444) begin tests_failed++; $display("FAIL svc_final_rd1: got %h expected %h", rd1_a, 16'h4444); end
  endtask

  task automatic test_zero_reg;
    do_reset();
    we = 1'b1; wa = 3'd0; wd = 16'hFFFF; iv = 1'b1; ia = 3'd0; ra1 = 3'd0;
    #1;
    tests_run++; if (rd1_z !== 16'h0000) begin tests_failed++; $display("FAIL zero_rd1_c0: got %h expected %h", rd1_z, 16'h0000); end
    tests_run++; if (busy1_z !== 1'b0) begin tests_failed++; $display("FAIL zero_busy1_c0: got %b expected %b", busy1_z, 1'b0); end
    tick();
    #1;
    tests_run++; if (rd1_z !== 16'h0000) begin tests_failed++; $display("FAIL zero_rd1_c1: got %h expected %h", rd1_z, 16'h0000); end
    tests_run++; if (busy_vec_z[0] !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_vec_c1: got %b expected %b", busy_vec_z[0], 1'b0); end
    tests_run++; if (rd1_a !== 16'hFFFF) begin tests_failed++; $display("FAIL zero_default_r0_bypass: got %h expected %h", rd1_a, 16'hFFFF); end
    tick();
    we = 1'b0; iv = 1'b0;
    #1;
    tests_run++; if (rd1_z !== 16'h0000) begin tests_failed++; $display("FAIL zero_rd1_c2: got %h expected %h", rd1_z, 16'h0000); end
    tests_run++; if (busy_vec_z !== 8'h00) begin tests_failed++; $display("FAIL zero_busy_vec_c2: got %h expected %h", busy_vec_z, 8'h00); end
    tests_run++; if (busy1_z !== 1'b0) begin tests_failed++; $display("FAIL zero_busy1_c2: got %b expected %b", busy1_z, 1'b0); end
    tests_run++; if (rd1_a !== 16'hFFFF) begin tests_failed++; $display("FAIL zero_default_r0_stored: got %h expected %h", rd1_a, 16'hFFFF); end
    tests_run++; if (busy_vec_a !== 8'h01) begin tests_failed++; $display("FAIL zero_default_r0_busy: got %h expected %h", busy_vec_a, 8'h01); end
  endtask

  task automatic test_invalid_addr;
    do_reset();
    we = 1'b1; wa = 3'd5; wd = 16'h5555;
    tick();
    we = 1'b1; wa = 3'd7; wd = 16'hAAAA; iv = 1'b1; ia = 3'd7; ra1 = 3'd7; ra2 = 3'd5;
    #1;
    tests_run++; if (rd1_6 !== 16'h0000) begin tests_failed++; $display("FAIL inv_rd1_bypass: got %h expected %h", rd1_6, 16'h0000); end
    tests_run++; if (busy1_6 !== 1'b0) begin tests_failed++; $display("FAIL inv_busy1: got %b expected %b", busy1_6, 1'b0); end
    tests_run++; if (rd2_6 !== 16'h5555) begin tests_failed++; $display("FAIL inv_rd2_valid: got %h expected %h", rd2_6, 16'h5555); end
    tick();
    wa = 3'd6; ia = 3'd6; ra1 = 3'd6;
    #1;
    tests_run++; if (rd1_6 !== 16'h0000) begin tests_failed++; $display("FAIL inv_rd1_addr6: got %h expected %h", rd1_6, 16'h0000); end
    tick();
    we = 1'b0; iv = 1'b0; ra1 = 3'd7;
    #1;
    tests_run++; if (busy_vec_6 !== 6'h00) begin tests_failed++; $display("FAIL inv_busy_vec: got %h expected %h", busy_vec_6, 6'h00); end
    tests_run++; if (rd1_6 !== 16'h0000) begin tests_failed++; $display("FAIL inv_rd1_after: got %h expected %h", rd1_6, 16'h0000); end
    tests_run++; if (rd2_6 !== 16'h5555) begin tests_failed++; $display("FAIL inv_rd2_unchanged: got %h expected %h", rd2_6, 16'h5555); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    we = 1'b1; wa = 3'd1; wd = 16'h1111; iv = 1'b1; ia = 3'd7;
    tick();
    wa = 3'd7; wd = 16'h7777; ia = 3'd1;
    #1;
    tests_run++; if (busy_vec_a !== 8'h80) begin tests_failed++; $display("FAIL b2b_busy_c1: got %h expected %h", busy_vec_a, 8'h80); end
    tick();
    we = 1'b0; iv = 1'b0; ra1 = 3'd1; ra2 = 3'd7;
    #1;
    tests_run++; if (busy_vec_a !== 8'h02) begin tests_failed++; $display("FAIL b2b_busy_c2: got %h expected %h", busy_vec_a, 8'h02); end
    tests_run++; if (rd1_a !== 16'h1111) begin tests_failed++; $display("FAIL b2b_rd1: got %h expected %h", rd1_a, 16'h1111); end
    tests_run++; if (rd2_a !== 16'h7777) begin tests_failed++; $display("FAIL b2b_rd2: got %h expected %h", rd2_a, 16'h7777); end
    tests_run++; if (busy1_a !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy1: got %b expected %b", busy1_a, 1'b1); end
    tests_run++; if (busy2_a !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy2: got %b expected %b", busy2_a, 1'b0); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    we = 1'b0; wa = 3'd0; wd = 16'h0000;
    iv = 1'b0; ia = 3'd0;
    ra1 = 3'd0; ra2 = 3'd0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_bypass();
    test_scoreboard();
    test_set_vs_clear();
    test_zero_reg();
    test_invalid_addr();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
